add_seq_controller: RTL and testbench
=====================================

Name: add_seq_controller

Overview:
- Sequencer for the ROM-fed accumulating datapath: ROM indexed by word address, a pipeline data register, then an alu32 add into a 32-bit accumulator register.
- On a start handshake it clears the accumulator and issues COUNT consecutive word addresses from BASE.
- It drives the data-register and accumulator enables with the one-cycle pipeline offset, then pulses done.
- Sits between a host/testbench and the existing register/alu32/adding_machine_memory datapath; contains no arithmetic on data.

Parameters:
- CNT_W, 16, width of the element-count input and internal remaining-count register.
- ADDR_W, 30, word-address width (byte address bits [31:2]).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- base  input  ADDR_W  first word address; latched when start is accepted.
- count  input  CNT_W  number of elements; latched when start is accepted.
- rom_addr  output  ADDR_W  word address to ROM (index[31:2]).
- data_en  output  1  enable for the pipeline data register (ROM output capture).
- acc_clear  output  1  synchronous clear of the accumulator register.
- acc_en  output  1  enable for the accumulator register (acc <= acc + data_reg).
- busy  output  1  high from CLEAR through DRAIN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE; rom_addr=0; data_en, acc_clear, acc_en, busy, done all 0; latched base/count=0.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE. All outputs are decoded from registered state, counters and pipeline flag; no start->output combinational path.
- IDLE: start=1 -> CLEAR and latch base/count; otherwise stay.
- CLEAR (1 cycle): acc_clear=1, busy=1; rom_addr=base. Next state is ISSUE if count!=0, else DONE.
- ISSUE: rom_addr=base+i for i=0..count-1, one per cycle; data_en=1; remaining counter decrements. After the issue with remaining==1, go to DRAIN.
- acc_en is data_en delayed one cycle (registered flag): asserted in ISSUE cycles 2..count, and in DRAIN.
- DRAIN (1 cycle): acc_en=1, data_en=0, busy=1. Next state is DONE.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE. start is ignored in DONE.
- Timing for start sampled at edge 0:
  - CLEAR in cycle 1.
  - Issues in cycles 2..count+1.
  - acc_en in cycles 3..count+2.
  - done in cycle count+3.
  - The accumulator holds the final sum from cycle count+3 onward.
- count==0: CLEAR then DONE (done in cycle 2); no data_en or acc_en.
- rom_addr is held at its last value outside ISSUE; it updates to base in CLEAR.
- Address arithmetic is modulo 2^ADDR_W. Example: base=30'h3FFFFFFF, count=2 issues 3FFFFFFF then 0.
- start while busy or in DONE: ignored; no queueing.
- Reset mid-operation: the next edge forces IDLE with all outputs 0. There is no done pulse, and the in-flight acc_en is dropped.

Optional Feature:
- Macro ADD_SEQ_ABORT_EN.
- With the macro defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in CLEAR or ISSUE -> next state DRAIN. The already-issued element is still accumulated; no further issues.
  - DONE then pulses done=1 and aborted=1 together.
  - abort is ignored in IDLE, DRAIN and DONE.
  - aborted resets to 0.
- Without the macro: neither port exists and the sequence always runs to count.

Decomposition:
- Shared include/package holds:
  - state encodings as defines: ADD_SEQ_IDLE, ADD_SEQ_CLEAR, ADD_SEQ_ISSUE, ADD_SEQ_DRAIN, ADD_SEQ_DONE (3-bit);
  - default CNT_W.
- State, index, remaining-count and acc_en-delay storage use the existing parameterized register module (enable, synchronous reset).
- One natural sub-module: add_seq_index_gen. It contains the index register plus an adder30 increment, with load-base and step controls.

Test Plan:
- Reset, then start with base=4, count=3 at edge 0:
  - acc_clear in cycle 1;
  - rom_addr 4,5,6 in cycles 2-4 with data_en=1;
  - acc_en in cycles 3-5;
  - done in cycle 6;
  - busy high in cycles 1-5.
- count=0, base=9: acc_clear in cycle 1, done in cycle 2, no data_en/acc_en.
- start pulsed again in cycles 2 and 6 of a count=3 run: ignored, single done only.
- base=30'h3FFFFFFF, count=2: rom_addr 3FFFFFFF then 00000000.
- Reset asserted in cycle 3 of a count=5 run: all outputs 0 from cycle 4, no done. A fresh start afterwards runs normally.
- With ADD_SEQ_ABORT_EN, count=8, abort in cycle 4:
  - issues for base..base+2 only;
  - acc_en in cycles 3-5;
  - done and aborted in cycle 6.
- Full datapath hooked up, ROM words 1,2,3 at base: accumulator equals 6 when done is high.

Source files
------------

// File: rtl/add_seq_controller_pkg.sv
// ============================================================================
// add_seq_controller_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the ROM-fed accumulate sequencer:
//   - add_seq_state_e : 3-bit sequencer state encoding
//   - ADD_SEQ_CNT_W   : default element-count width
//   - ADD_SEQ_ADDR_W  : default word-address width (byte address bits [31:2])
// ============================================================================
package add_seq_controller_pkg;

    localparam int ADD_SEQ_CNT_W  = 16;
    localparam int ADD_SEQ_ADDR_W = 30;

    typedef enum logic [2:0] {
        ADD_SEQ_IDLE  = 3'd0,
        ADD_SEQ_CLEAR = 3'd1,
        ADD_SEQ_ISSUE = 3'd2,
        ADD_SEQ_DRAIN = 3'd3,
        ADD_SEQ_DONE  = 3'd4
    } add_seq_state_e;

endpackage : add_seq_controller_pkg

// File: rtl/add_seq_index_gen.sv
// ============================================================================
// add_seq_index_gen
// ----------------------------------------------------------------------------
// Word-address register with an increment path. Load takes priority over step;
// with neither asserted the index holds. The increment wraps modulo 2^ADDR_W.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset (index -> 0)
//   load   in   load index from base
//   step   in   index <= index + 1
//   base   in   [ADDR_W] value loaded on load
//   index  out  [ADDR_W] current word address
// ============================================================================
module add_seq_index_gen #(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] index
);

    logic [ADDR_W-1:0] index_d;
    logic [ADDR_W-1:0] index_q;

    always_comb begin
        index_d = index_q;
        if (load) begin
            index_d = base;
        end else if (step) begin
            index_d = index_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule : add_seq_index_gen

// File: rtl/add_seq_controller.sv
// ============================================================================
// add_seq_controller
// ----------------------------------------------------------------------------
// Sequencer for a ROM -> data register -> accumulator datapath. On an accepted
// start it clears the accumulator, issues COUNT consecutive word addresses
// from BASE, enables the accumulator one cycle behind each data capture, then
// pulses done. All outputs decode from registered state only.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request, sampled only in IDLE
//   base       in   [ADDR_W] first word address, latched on accept
//   count      in   [CNT_W]  element count, latched on accept
//   rom_addr   out  [ADDR_W] word address to the ROM
//   data_en    out  data register capture enable
//   acc_clear  out  accumulator synchronous clear
//   acc_en     out  accumulator enable (acc <= acc + data_reg)
//   busy       out  high from CLEAR through DRAIN
//   done       out  one-cycle completion pulse
//   abort      in   (ADD_SEQ_ABORT_EN only) stop issuing, drain, finish
//   aborted    out  (ADD_SEQ_ABORT_EN only) pulses with done after an abort
//
// Build option: define ADD_SEQ_ABORT_EN to add the abort/aborted ports.
// ============================================================================
module add_seq_controller
    import add_seq_controller_pkg::*;
#(
    parameter int CNT_W  = ADD_SEQ_CNT_W,
    parameter int ADDR_W = ADD_SEQ_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
`ifdef ADD_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic              data_en,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              busy,
    output logic              done
);

    add_seq_state_e   state_d, state_q;
    logic [CNT_W-1:0] remaining_d, remaining_q;
    logic             acc_en_d, acc_en_q;
    logic             idx_load, idx_step;
    logic             abort_req;

`ifdef ADD_SEQ_ABORT_EN
    logic aborted_d, aborted_q;
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    add_seq_index_gen #(
        .ADDR_W (ADDR_W)
    ) u_index_gen (
        .clk   (clk),
        .reset (reset),
        .load  (idx_load),
        .step  (idx_step),
        .base  (base),
        .index (rom_addr)
    );

    // NOTE: every signal gets a default at the top of the block so that no
    // path through the case statement leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_load    = 1'b0;
        idx_step    = 1'b0;
        // The accumulator consumes the data register one cycle after capture.
        acc_en_d    = (state_q == ADD_SEQ_ISSUE);

        unique case (state_q)
            ADD_SEQ_IDLE: begin
                if (start) begin
                    state_d     = ADD_SEQ_CLEAR;
                    remaining_d = count;
                    idx_load    = 1'b1;
                end
            end
            ADD_SEQ_CLEAR: begin
                if (abort_req) begin
                    state_d = ADD_SEQ_DRAIN;
                end else if (remaining_q != '0) begin
                    state_d = ADD_SEQ_ISSUE;
                end else begin
                    state_d = ADD_SEQ_DONE;
                end
            end
            ADD_SEQ_ISSUE: begin
                remaining_d = remaining_q - CNT_W'(1);
                // The last issued address stays on rom_addr, so only step
                // when another issue follows.
                if (abort_req || remaining_q == CNT_W'(1)) begin
                    state_d = ADD_SEQ_DRAIN;
                end else begin
                    idx_step = 1'b1;
                end
            end
            ADD_SEQ_DRAIN: state_d = ADD_SEQ_DONE;
            ADD_SEQ_DONE:  state_d = ADD_SEQ_IDLE;
            default:       state_d = ADD_SEQ_IDLE;
        endcase
    end

`ifdef ADD_SEQ_ABORT_EN
    always_comb begin
        aborted_d = aborted_q;
        if (state_q == ADD_SEQ_IDLE && start) begin
            aborted_d = 1'b0;
        end else if ((state_q == ADD_SEQ_CLEAR || state_q == ADD_SEQ_ISSUE) && abort) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = (state_q == ADD_SEQ_DONE) && aborted_q;
`endif

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ADD_SEQ_IDLE;
            remaining_q <= '0;
            acc_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_en_q    <= acc_en_d;
        end
    end

    assign acc_clear = (state_q == ADD_SEQ_CLEAR);
    assign data_en   = (state_q == ADD_SEQ_ISSUE);
    assign acc_en    = acc_en_q;
    assign busy      = (state_q == ADD_SEQ_CLEAR) || (state_q == ADD_SEQ_ISSUE)
                    || (state_q == ADD_SEQ_DRAIN);
    assign done      = (state_q == ADD_SEQ_DONE);

endmodule : add_seq_controller

// File: tb/tb_add_seq_controller.sv
// ============================================================================
// tb_add_seq_controller
// ----------------------------------------------------------------------------
// Directed bench for add_seq_controller. Cycle N is the interval after the
// N-th rising edge counted from the edge that samples start (edge 0). Also
// models the ROM / data register / accumulator datapath to confirm the sum.
// Define ADD_SEQ_ABORT_EN to also exercise the abort option.
// ============================================================================
module tb_add_seq_controller;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 30;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] rom_addr;
    logic              data_en, acc_clear, acc_en, busy, done;
`ifdef ADD_SEQ_ABORT_EN
    logic              abort;
    logic              aborted;
`endif

    int errors = 0;
    int checks = 0;

    add_seq_controller #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
`ifdef ADD_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .rom_addr  (rom_addr),
        .data_en   (data_en),
        .acc_clear (acc_clear),
        .acc_en    (acc_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath model: ROM, data register, accumulator -------
    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a >= 30'd100 && a <= 30'd102) return 32'(a) - 32'd99;
        return 32'd1000;
    endfunction

    logic [31:0] data_reg = '0;
    logic [31:0] acc      = '0;
    logic [31:0] acc_at_done;

    always @(posedge clk) begin
        if (data_en) data_reg <= rom_word(rom_addr);
        if (acc_clear)   acc <= '0;
        else if (acc_en) acc <= acc + data_reg;
    end

    // ---------------- helpers -----------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [ADDR_W-1:0] e_addr,
                              input logic e_den, input logic e_clr, input logic e_aen,
                              input logic e_busy, input logic e_done);
        check({tag, " rom_addr"},  32'(rom_addr), 32'(e_addr));
        check({tag, " data_en"},   32'(data_en),  32'(e_den));
        check({tag, " acc_clear"}, 32'(acc_clear), 32'(e_clr));
        check({tag, " acc_en"},    32'(acc_en),   32'(e_aen));
        check({tag, " busy"},      32'(busy),     32'(e_busy));
        check({tag, " done"},      32'(done),     32'(e_done));
    endtask

    // Full run: start at edge 0, then check cycles 1..max_c against the
    // timeline: CLEAR@1, issues@2..n+1, acc_en@3..n+2, done@n+3 (2 if n==0).
    // start_mask bit c drives start during cycle c (should be ignored).
    task automatic run_seq(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                           input logic [31:0] start_mask, input int max_c, input string name);
        int                n_i;
        int                done_c;
        int                busy_last;
        logic [ADDR_W-1:0] ea;
        n_i       = int'(n);
        done_c    = (n_i == 0) ? 2 : n_i + 3;
        busy_last = (n_i == 0) ? 1 : n_i + 2;
        base  = b;
        count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            if (c == 1)                      ea = b;
            else if (n_i != 0 && c <= n_i + 1) ea = b + ADDR_W'(c - 2);
            else if (n_i == 0)               ea = b;
            else                             ea = b + ADDR_W'(n_i - 1);
            check_outs($sformatf("%s c%0d", name, c), ea,
                       (c >= 2 && c <= n_i + 1),
                       (c == 1),
                       (c >= 3 && c <= n_i + 2),
                       (c <= busy_last),
                       (c == done_c));
`ifdef ADD_SEQ_ABORT_EN
            check($sformatf("%s c%0d aborted", name, c), 32'(aborted), 32'd0);
`endif
            if (c == done_c) acc_at_done = acc;
            start = start_mask[c];
            tick();
        end
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        count = '0;
`ifdef ADD_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        check_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADD_SEQ_ABORT_EN
        check("reset aborted", 32'(aborted), 32'd0);
`endif
        reset = 1'b0;
        tick();
        check_outs("idle", '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_seq(30'd4, 16'd3, 32'h0, 8, "basic");
        run_seq(30'd9, 16'd0, 32'h0, 5, "zero");
        run_seq(30'd7, 16'd3, (32'd1 << 2) | (32'd1 << 6), 9, "restart");
        run_seq(30'h3FFFFFFF, 16'd2, 32'h0, 6, "wrap");

        // Reset asserted during cycle 3 of a count=5 run.
        base  = 30'd20;
        count = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 4; c <= 10; c++) begin
            check_outs($sformatf("midreset c%0d", c), '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Fresh run after reset, with the datapath sum checked at done.
        acc_at_done = 32'hFFFF_FFFF;
        run_seq(30'd100, 16'd3, 32'h0, 7, "datapath");
        check("datapath acc at done", acc_at_done, 32'd6);

`ifdef ADD_SEQ_ABORT_EN
        // count=8, abort during cycle 4: issues 50..52, acc_en 3..5, done 6.
        base  = 30'd50;
        count = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            logic [ADDR_W-1:0] ea;
            if (c == 1)      ea = 30'd50;
            else if (c <= 4) ea = 30'd50 + ADDR_W'(c - 2);
            else             ea = 30'd52;
            check_outs($sformatf("abort c%0d", c), ea,
                       (c >= 2 && c <= 4), (c == 1), (c >= 3 && c <= 5),
                       (c <= 5), (c == 6));
            check($sformatf("abort c%0d aborted", c), 32'(aborted), 32'(c == 6));
            abort = (c == 4);
            tick();
        end
        abort = 1'b0;
        run_seq(30'd5, 16'd1, 32'h0, 5, "after_abort");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_add_seq_controller
